key_debounce: RTL and testbench

Input conditioning stage for the 4-bit adder front panel. Sits between the board pins and the adder/display block. Synchronises and debounces the three push keys (`key_a`, `key_b`, `key_cal`) and the 4-bit switch bank. Delivers clean active-low key levels, single-cycle press pulses and a stable switch value, so the downstream block samples each operand and each calculate request exactly once per physical press.

---
 rtl/key_debounce.sv | 193 +++++++++++++++++++
 tb/tb_key_debounce.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces the three front-panel push keys
// and the 4-bit switch bank feeding the adder/display block. Each key gets a
// four-state press/release FSM that yields a clean active-low level and a
// single-clock press pulse. The switch bank is filtered as one 4-bit word.
// A change is accepted only after DEB_CYCLES consecutive matching
// synchronised samples. Total latency is DEB_CYCLES+2 clocks from the raw pin.
module key_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_a_raw,
  input  logic       key_b_raw,
  input  logic       key_cal_raw,
  input  logic [3:0] sw_raw,
  output logic       key_a,
  output logic       key_b,
  output logic       key_cal,
  output logic       key_a_pls,
  output logic       key_b_pls,
  output logic       key_cal_pls,
  output logic [3:0] sw_dig
);

  // The sample that opens a wait is the first of the DEB_CYCLES, so the
  // counter accepts when it already holds DEB_CYCLES-2 further samples.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    REL   = 2'd0,
    PWAIT = 2'd1,
    PRS   = 2'd2,
    RWAIT = 2'd3
  } key_st_e;

  // Increment that sticks at DEB_CYCLES-1 instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1'b1;
  endfunction

  logic [2:0] key_raw;
  logic [2:0] key_sync_p0;
  logic [2:0] key_sync_p1;
  logic [2:0] key_lvl;
  logic [2:0] key_pls;

  assign key_raw = {key_cal_raw, key_b_raw, key_a_raw};

  // ---- stage p0/p1: two-flop synchronisers, keys idle high (released)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_sync_p0 <= 3'b111;
      key_sync_p1 <= 3'b111;
    end else begin
      key_sync_p0 <= key_raw;
      key_sync_p1 <= key_sync_p0;
    end
  end

  // ---- decision stage: one independent FSM per key
  for (genvar k = 0; k < 3; k++) begin : g_key
    key_st_e          st;
    key_st_e          st_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             lvl;
    logic             lvl_nx;
    logic             pls;
    logic             pls_nx;
    logic             in_s;

    assign in_s = key_sync_p1[k];

    // State, counter and registered level/pulse.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st  <= REL;
        cnt <= '0;
        lvl <= 1'b1;
        pls <= 1'b0;
      end else begin
        st  <= st_nx;
        cnt <= cnt_nx;
        lvl <= lvl_nx;
        pls <= pls_nx;
      end
    end

    // Next state: any contrary sample during a wait falls back to the
    // settled state, so bounce restarts the count.
    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      case (st)
        REL: begin
          if (!in_s) begin
            st_nx  = PWAIT;
            cnt_nx = '0;
          end
        end
        PWAIT: begin
          if (in_s) begin
            st_nx  = REL;
            cnt_nx = '0;
          end else if (cnt == CNT_LAST) begin
            st_nx  = PRS;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt_sat_inc(cnt);
          end
        end
        PRS: begin
          if (in_s) begin
            st_nx  = RWAIT;
            cnt_nx = '0;
          end
        end
        RWAIT: begin
          if (!in_s) begin
            st_nx  = PRS;
            cnt_nx = '0;
          end else if (cnt == CNT_LAST) begin
            st_nx  = REL;
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt_sat_inc(cnt);
          end
        end
        default: begin
          st_nx  = REL;
          cnt_nx = '0;
        end
      endcase
    end

    // Outputs: level follows accepted transitions, pulse only on press.
    always_comb begin
      lvl_nx = lvl;
      pls_nx = 1'b0;
      if (st == PWAIT && st_nx == PRS) begin
        lvl_nx = 1'b0;
        pls_nx = 1'b1;
      end else if (st == RWAIT && st_nx == REL) begin
        lvl_nx = 1'b1;
      end
    end

    assign key_lvl[k] = lvl;
    assign key_pls[k] = pls;
  end

  assign key_a       = key_lvl[0];
  assign key_b       = key_lvl[1];
  assign key_cal     = key_lvl[2];
  assign key_a_pls   = key_pls[0];
  assign key_b_pls   = key_pls[1];
  assign key_cal_pls = key_pls[2];

  logic [3:0]       sw_sync_p0;
  logic [3:0]       sw_sync_p1;
  logic [3:0]       sw_cand;
  logic [CNT_W-1:0] sw_cnt;

  // ---- stage p0/p1: switch synchronisers, then word-wide debounce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_sync_p0 <= '0;
      sw_sync_p1 <= '0;
      sw_cand    <= '0;
      sw_cnt     <= '0;
      sw_dig     <= '0;
    end else begin
      sw_sync_p0 <= sw_raw;
      sw_sync_p1 <= sw_sync_p0;
      if (sw_sync_p1 != sw_cand) begin
        sw_cand <= sw_sync_p1;
        sw_cnt  <= '0;
      end else if (sw_cand != sw_dig) begin
        if (sw_cnt == CNT_LAST) begin
          sw_dig <= sw_cand;
          sw_cnt <= '0;
        end else begin
          sw_cnt <= cnt_sat_inc(sw_cnt);
        end
      end else begin
        sw_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEB_CYCLES=8: a table of steady-state input
// vectors plus hand-written glitch, bounce and reset sequences. Expected
// outputs are queued with the cycle they are due and compared on the
// falling edge of that cycle.
module tb_key_debounce;
  localparam int DEB = 8;
  localparam int CW  = 4;
  localparam int LAT = DEB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ka = 1'b1, kb = 1'b1, kc = 1'b1;
  logic [3:0] sw = 4'd0;
  logic       key_a, key_b, key_cal, key_a_pls, key_b_pls, key_cal_pls;
  logic [3:0] sw_dig;

  key_debounce #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .key_a_raw(ka), .key_b_raw(kb), .key_cal_raw(kc), .sw_raw(sw),
    .key_a(key_a), .key_b(key_b), .key_cal(key_cal),
    .key_a_pls(key_a_pls), .key_b_pls(key_b_pls), .key_cal_pls(key_cal_pls),
    .sw_dig(sw_dig)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pc [3] = '{0, 0, 0};
  always @(negedge clk) begin
    pc[0] <= pc[0] + int'(key_a_pls);
    pc[1] <= pc[1] + int'(key_b_pls);
    pc[2] <= pc[2] + int'(key_cal_pls);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // {key_cal, key_b, key_a, cal_pls, b_pls, a_pls, sw_dig}
  function automatic logic [9:0] obs();
    return {key_cal, key_b, key_a, key_cal_pls, key_b_pls, key_a_pls, sw_dig};
  endfunction

  typedef struct {
    int         at;
    logic [2:0] lvl;
    logic [2:0] pls;
    logic [3:0] sw;
    string      nm;
  } exp_t;

  exp_t sb [$];
  exp_t e;

  task automatic push(input int at, input logic [2:0] lvl, input logic [2:0] pls,
                      input logic [3:0] s, input string nm);
    exp_t x;
    x.at = at; x.lvl = lvl; x.pls = pls; x.sw = s; x.nm = nm;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      check(e.nm, 32'(obs()), 32'({e.lvl, e.pls, e.sw}));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       a, b, c;
    logic [3:0] sw;
    logic [2:0] lvl;   // {cal, b, a}
    logic [3:0] swd;
    string      nm;
  } vec_t;

  vec_t       tbl [8];
  logic [2:0] cur_lvl;
  logic [3:0] cur_sw;
  logic [2:0] p_exp;
  int         c0, cf;
  int         snap [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{a:1'b0, b:1'b1, c:1'b1, sw:4'd0,  lvl:3'b110, swd:4'd0,  nm:"press_a"};
    tbl[1] = '{a:1'b1, b:1'b1, c:1'b1, sw:4'd0,  lvl:3'b111, swd:4'd0,  nm:"release_a"};
    tbl[2] = '{a:1'b0, b:1'b1, c:1'b0, sw:4'd0,  lvl:3'b010, swd:4'd0,  nm:"press_a_cal"};
    tbl[3] = '{a:1'b1, b:1'b1, c:1'b1, sw:4'd0,  lvl:3'b111, swd:4'd0,  nm:"release_all"};
    tbl[4] = '{a:1'b1, b:1'b1, c:1'b1, sw:4'd9,  lvl:3'b111, swd:4'd9,  nm:"sw_0_to_9"};
    tbl[5] = '{a:1'b1, b:1'b1, c:1'b1, sw:4'd15, lvl:3'b111, swd:4'd15, nm:"sw_9_to_15"};
    tbl[6] = '{a:1'b1, b:1'b0, c:1'b1, sw:4'd3,  lvl:3'b101, swd:4'd3,  nm:"press_b_sw3"};
    tbl[7] = '{a:1'b1, b:1'b1, c:1'b1, sw:4'd9,  lvl:3'b111, swd:4'd9,  nm:"release_b_sw9"};

    // Reset state
    rst = 1'b0;
    tick(3);
    check("reset_state", 32'(obs()), 32'({3'b111, 3'b000, 4'd0}));
    rst = 1'b1;
    tick(12);
    check("idle_after_reset", 32'(obs()), 32'({3'b111, 3'b000, 4'd0}));
    cur_lvl = 3'b111;
    cur_sw  = 4'd0;

    // Table-driven steady-state transitions
    for (int i = 0; i < 8; i++) begin
      snap = pc;
      c0 = cyc;
      ka = tbl[i].a; kb = tbl[i].b; kc = tbl[i].c; sw = tbl[i].sw;
      p_exp = cur_lvl & ~tbl[i].lvl;
      push(c0 + LAT - 1, cur_lvl,    3'b000, cur_sw,      {tbl[i].nm, "_before"});
      push(c0 + LAT,     tbl[i].lvl, p_exp,  tbl[i].swd,  {tbl[i].nm, "_edge"});
      push(c0 + LAT + 1, tbl[i].lvl, 3'b000, tbl[i].swd,  {tbl[i].nm, "_after"});
      cur_lvl = tbl[i].lvl;
      cur_sw  = tbl[i].swd;
      tick(15);
      check({tbl[i].nm, "_pulse_count"},
            32'({pc[2] - snap[2], pc[1] - snap[1], pc[0] - snap[0]}),
            32'({32'(p_exp[2]), 32'(p_exp[1]), 32'(p_exp[0])}));
    end

    // Short glitches: key A low for 7 clocks, switches at 4 for 5 clocks
    snap = pc;
    c0 = cyc;
    ka = 1'b0; sw = 4'd4;
    for (int i = 1; i <= 25; i++) push(c0 + i, 3'b111, 3'b000, 4'd9, "glitch_steady");
    tick(5);
    sw = 4'd9;
    tick(2);
    ka = 1'b1;
    tick(20);
    check("glitch_a_no_pulse", 32'(pc[0] - snap[0]), 32'd0);

    // Key B bounces every 3 clocks for 42 clocks, then held low
    snap = pc;
    for (int seg = 0; seg < 14; seg++) begin
      kb = (seg % 2 == 1);
      for (int j = 0; j < 3; j++) begin
        push(cyc, 3'b111, 3'b000, 4'd9, "bounce_quiet");
        tick(1);
      end
    end
    check("bounce_no_pulse", 32'(pc[1] - snap[1]), 32'd0);
    kb = 1'b0;
    cf = cyc;
    for (int i = 0; i < LAT; i++) push(cf + i, 3'b111, 3'b000, 4'd9, "bounce_settle");
    push(cf + LAT,     3'b101, 3'b010, 4'd9, "bounce_press_edge");
    push(cf + LAT + 1, 3'b101, 3'b000, 4'd9, "bounce_press_after");
    tick(15);
    check("bounce_single_pulse", 32'(pc[1] - snap[1]), 32'd1);
    kb = 1'b1;
    push(cyc + LAT + 1, 3'b111, 3'b000, 4'd9, "bounce_release");
    tick(15);

    // Mid-run asynchronous reset, then calculate key held across release
    c0 = cyc;
    ka = 1'b0;
    push(c0 + LAT, 3'b110, 3'b001, 4'd9, "pre_reset_press_a");
    tick(12);
    sw = 4'd5;
    tick(4);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_mid_run", 32'(obs()), 32'({3'b111, 3'b000, 4'd0}));
    snap = pc;
    kc = 1'b0; ka = 1'b1; sw = 4'd0;
    tick(5);
    check("reset_held_outputs", 32'(obs()), 32'({3'b111, 3'b000, 4'd0}));
    check("reset_held_no_pulse", 32'(pc[2] - snap[2]), 32'd0);
    rst = 1'b1;
    c0 = cyc;
    push(c0 + LAT - 1, 3'b111, 3'b000, 4'd0, "cal_thru_reset_before");
    push(c0 + LAT,     3'b011, 3'b100, 4'd0, "cal_thru_reset_edge");
    push(c0 + LAT + 1, 3'b011, 3'b000, 4'd0, "cal_thru_reset_after");
    tick(20);
    check("cal_thru_reset_once", 32'(pc[2] - snap[2]), 32'd1);
    kc = 1'b1;
    push(cyc + LAT + 1, 3'b111, 3'b000, 4'd0, "cal_release");
    tick(15);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
